// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register-access master: frame geometry,
// sequencer state encoding and the command-word builder.
// Frame layout (MSB first): {wr, 11'b0, addr[3:0], data[15:0]}
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS = 32;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int CMD_W      = FRAME_BITS - DATA_W;
  localparam int CMD_WR_BIT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Command word: write flag in the top bit, address in the low bits.
  function automatic logic [CMD_W-1:0] build_cmd(input logic wr,
                                                 input logic [ADDR_W-1:0] addr);
    logic [CMD_W-1:0] cmd;
    cmd                 = {CMD_W{1'b0}};
    cmd[CMD_WR_BIT]     = wr;
    cmd[ADDR_W-1:0]     = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
// Local parallel request bus between a fabric-side requester and the SPI
// master sequencer.
//   req   : single-cycle request strobe (requester -> sequencer)
//   wr    : 1 = write, 0 = read
//   addr  : slave register address
//   wdata : write data
//   busy  : frame in progress (sequencer -> requester)
//   done  : one-cycle completion pulse
//   rdata : last read result
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if;
  import spi_pkg::*;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output busy, done, rdata
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// SCLK half-period generator. While enabled, the level toggles every CLK_DIV
// clk cycles starting low; while disabled it is held at count 0, level low.
//   clk, rst : system clock, synchronous active-high reset
//   en       : run enable (held in reset when low)
//   sclk     : registered SCLK level
//   rise_stb : high in the last cycle of a low phase (sclk rises at this edge)
//   fall_stb : high in the last cycle of a high phase (sclk falls at this edge)
// ---------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] half_cnt_r;
  logic       sclk_r;
  logic       wrap_s;

  // End-of-half-period detection and edge strobes.
  always_comb begin
    wrap_s   = en && (half_cnt_r == DIV_M1);
    rise_stb = wrap_s && !sclk_r;
    fall_stb = wrap_s && sclk_r;
  end

  // Half-period counter and SCLK level register.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      half_cnt_r <= 8'd0;
      sclk_r     <= 1'b0;
    end else if (wrap_s) begin
      half_cnt_r <= 8'd0;
      sclk_r     <= ~sclk_r;
    end else begin
      half_cnt_r <= half_cnt_r + 8'd1;
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// SPI master sequencer: turns one accepted request into a complete 32-bit
// register-access frame (SSEL low, 32 SCLK periods, hold, SSEL-high gap) and
// captures the 16-bit read data for reads.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : local request bus (req/wr/addr/wdata in, busy/done/rdata out)
//   sclk     : SPI clock, idles low
//   ssel     : slave select, active low
//   mosi     : serial data out, MSB first, changes at low-phase start
//   miso     : serial data in, sampled in the last cycle of each high phase
// ---------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_ctrl_if.slave   bus,
  output logic               sclk,
  output logic               ssel,
  output logic               mosi,
  input  logic               miso
);

  localparam logic [7:0] DIV_M1    = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1    = 8'(GAP_CYCLES - 1);
  // Bit counter is advanced on each rising edge, so during the high phase of
  // bit k it reads k+1. Data bits 16..31 are therefore seen as 17..32.
  localparam logic [5:0] CAP_FIRST = 6'(CMD_W + 1);
  localparam logic [5:0] LAST_CNT  = 6'(FRAME_BITS);

  state_t                state_r, state_nxt;
  logic [FRAME_BITS-1:0] shreg_r, frame_s;
  logic [DATA_W-1:0]     cap_r, rdata_r;
  logic [5:0]            bit_cnt_r;
  logic [7:0]            wait_cnt_r;
  logic                  is_wr_r, busy_r, done_r, ssel_r;
  logic                  sclk_s, rise_stb_s, fall_stb_s, shift_en_s;
  logic                  accept_s, last_bit_s, hold_end_s, gap_end_s;

  assign shift_en_s = (state_r == SHIFT);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (shift_en_s),
    .sclk     (sclk_s),
    .rise_stb (rise_stb_s),
    .fall_stb (fall_stb_s)
  );

  // Frame image loaded at acceptance; reads send zeros in the data word.
  always_comb begin
    if (bus.wr) begin
      frame_s = {build_cmd(bus.wr, bus.addr), bus.wdata};
    end else begin
      frame_s = {build_cmd(bus.wr, bus.addr), {DATA_W{1'b0}}};
    end
  end

  // Sequencer next-state logic and phase-end strobes.
  always_comb begin
    state_nxt  = state_r;
    accept_s   = 1'b0;
    last_bit_s = 1'b0;
    hold_end_s = 1'b0;
    gap_end_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          state_nxt = SHIFT;
          accept_s  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (fall_stb_s && (bit_cnt_r == LAST_CNT)) begin
          state_nxt  = HOLD;
          last_bit_s = 1'b1;
        end else begin
          state_nxt = SHIFT;
        end
      end
      HOLD: begin
        if (wait_cnt_r == DIV_M1) begin
          state_nxt  = GAP;
          hold_end_s = 1'b1;
        end else begin
          state_nxt = HOLD;
        end
      end
      GAP: begin
        if (wait_cnt_r == GAP_M1) begin
          state_nxt = IDLE;
          gap_end_s = 1'b1;
        end else begin
          state_nxt = GAP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Frame datapath: shift register, counters, capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r    <= {FRAME_BITS{1'b0}};
      cap_r      <= {DATA_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
      bit_cnt_r  <= 6'd0;
      wait_cnt_r <= 8'd0;
      is_wr_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ssel_r     <= 1'b1;
    end else begin
      done_r <= 1'b0;

      if (accept_s) begin
        shreg_r   <= frame_s;
        cap_r     <= {DATA_W{1'b0}};
        bit_cnt_r <= 6'd0;
        is_wr_r   <= bus.wr;
        busy_r    <= 1'b1;
        ssel_r    <= 1'b0;
      end

      if (rise_stb_s) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end

      // Falling edge starts the next low phase: present the next bit and
      // sample MISO for the data half of the frame.
      if (fall_stb_s) begin
        shreg_r <= {shreg_r[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt_r >= CAP_FIRST) begin
          cap_r <= {cap_r[DATA_W-2:0], miso};
        end
      end

      if (hold_end_s) begin
        ssel_r <= 1'b1;
      end

      if (gap_end_s) begin
        done_r <= 1'b1;
        busy_r <= 1'b0;
        if (!is_wr_r) begin
          rdata_r <= cap_r;
        end
      end

      // Shared wait counter times both the HOLD and the GAP phase.
      if (last_bit_s || hold_end_s) begin
        wait_cnt_r <= 8'd0;
      end else if ((state_r == HOLD) || (state_r == GAP)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
    end
  end

  // MOSI is the MSB of the shift register, so it idles low once shifted out.
  assign mosi      = shreg_r[FRAME_BITS-1];
  assign sclk      = sclk_s;
  assign ssel      = ssel_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl: default instance (CLK_DIV=4, GAP=4)
// checked through a frame/rdata scoreboard and a bus monitor, plus a second
// instance (CLK_DIV=2, GAP=1) checked inline.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, ssel, mosi;
  logic miso = 1'b1;
  logic sclk2, ssel2, mosi2;
  logic miso2 = 1'b1;

  spi_master_ctrl_if bus ();
  spi_master_ctrl_if bus2 ();

  spi_master_ctrl #(.CLK_DIV(4), .GAP_CYCLES(4)) dut (
    .clk (clk), .rst (rst), .bus (bus),
    .sclk (sclk), .ssel (ssel), .mosi (mosi), .miso (miso)
  );

  spi_master_ctrl #(.CLK_DIV(2), .GAP_CYCLES(1)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2),
    .sclk (sclk2), .ssel (ssel2), .mosi (mosi2), .miso (miso2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [31:0] exp_frame[$];
  logic [15:0] exp_rdata[$];
  logic [15:0] miso_pat    = 16'h0000;
  logic [15:0] model_rdata = 16'h0000;

  // monitor state
  logic        prev_sclk = 1'b0;
  logic        prev_ssel = 1'b1;
  int          fall_edge = 0, rise_edge = 0, done_edge = 0;
  int          nbits = 0, done_cnt = 0;
  logic [31:0] mon_frame = 32'h0;
  bit          skip = 1'b0;
  bit          b2b  = 1'b0;

  // second-instance measurements
  int          r1 = 0, r2 = 0, dr = 0, base = 0;
  logic        p2 = 1'b0;
  logic [31:0] f2 = 32'h0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input logic w, input logic [3:0] a, input logic [15:0] d);
    logic [31:0] f;
    f = {w, 11'd0, a, 16'h0000};
    if (w) f[15:0] = d;
    exp_frame.push_back(f);
    if (w) begin
      exp_rdata.push_back(model_rdata);
    end else begin
      model_rdata = miso_pat;
      exp_rdata.push_back(miso_pat);
    end
  endtask

  // Drive a request during one cycle (or keep it high when hold is set).
  task automatic start(input logic w, input logic [3:0] a, input logic [15:0] d,
                       input bit hold, input bit sb);
    bus.wr = w; bus.addr = a; bus.wdata = d; bus.req = 1'b1;
    if (sb) expect_frame(w, a, d);
    @(negedge clk);
    if (!hold) bus.req = 1'b0;
    check("busy_rise", 32'(bus.busy), 32'd1);
    check("ssel_fall", 32'(ssel), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  // Bus monitor and MISO slave model for the default instance.
  initial begin
    forever begin
      @(negedge clk);
      if (ssel === 1'b0 && prev_ssel === 1'b1) begin
        if (b2b) begin
          check("b2b_gap", 32'(edge_cnt - rise_edge), 32'd5);
          check("b2b_refall", 32'(edge_cnt - done_edge), 32'd1);
        end
        fall_edge = edge_cnt;
        nbits     = 0;
        mon_frame = 32'h0;
      end
      if (ssel === 1'b0 && sclk === 1'b1 && prev_sclk === 1'b0) begin
        nbits++;
        mon_frame = {mon_frame[30:0], mosi};
        if (nbits == 1 && !skip) check("first_rise", 32'(edge_cnt - fall_edge + 1), 32'd5);
        if (nbits >= 17) miso = miso_pat[32 - nbits];
        else miso = 1'b1;
      end
      if (ssel === 1'b1 && prev_ssel === 1'b0) begin
        rise_edge = edge_cnt;
        if (!skip) begin
          check("nbits", 32'(nbits), 32'd32);
          check("ssel_low", 32'(edge_cnt - fall_edge), 32'd260);
          if (exp_frame.size() > 0) begin
            check("frame", mon_frame, exp_frame.pop_front());
          end else begin
            n_vec++; n_err++;
            $error("FAIL frame_sb: unexpected frame %0h", mon_frame);
          end
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_edge = edge_cnt;
        if (!skip) begin
          check("done_cycle", 32'(edge_cnt - fall_edge + 1), 32'd265);
          check("busy_at_done", 32'(bus.busy), 32'd0);
          if (exp_rdata.size() > 0) begin
            check("rdata", 32'(bus.rdata), 32'(exp_rdata.pop_front()));
          end else begin
            n_vec++; n_err++;
            $error("FAIL rdata_sb: unexpected done, rdata %0h", bus.rdata);
          end
        end
      end
      prev_sclk = sclk;
      prev_ssel = ssel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 4'h0; bus.wdata = 16'h0;
    bus2.req = 1'b0; bus2.wr = 1'b0; bus2.addr = 4'h0; bus2.wdata = 16'h0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_sclk",  32'(sclk),      32'd0);
    check("rst_ssel",  32'(ssel),      32'd1);
    check("rst_mosi",  32'(mosi),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // write addr 3, 16'hA5C3
    start(1'b1, 4'h3, 16'hA5C3, 1'b0, 1'b1);
    wait_done(300);
    repeat (3) @(negedge clk);
    check("wr_rdata_hold", 32'(bus.rdata), 32'd0);

    // read addr 9, slave returns 16'h1234 (wdata must not appear on the wire)
    miso_pat = 16'h1234;
    start(1'b0, 4'h9, 16'hBEEF, 1'b0, 1'b1);
    wait_done(300);
    repeat (5) @(negedge clk);
    check("rd_rdata_hold", 32'(bus.rdata), 32'h1234);

    // requests at cycles 10 and 100 of a frame are ignored
    base = done_cnt;
    start(1'b1, 4'h6, 16'h0F0F, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 4'hE; bus.wdata = 16'hFFFF;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (89) @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 4'hB; bus.wdata = 16'h5555;
    @(negedge clk);
    bus.req = 1'b0;
    wait_done(300);
    repeat (20) @(negedge clk);
    check("ignored_req_dones", 32'(done_cnt - base), 32'd1);
    check("ignored_req_rdata", 32'(bus.rdata), 32'h1234);

    // reset at cycle 50 of a frame, new request at cycle 55
    start(1'b1, 4'hC, 16'h1357, 1'b0, 1'b0);
    base = done_cnt;
    repeat (49) @(negedge clk);
    skip = 1'b1;
    rst  = 1'b1;
    @(negedge clk);
    check("abort_ssel",  32'(ssel),      32'd1);
    check("abort_sclk",  32'(sclk),      32'd0);
    check("abort_mosi",  32'(mosi),      32'd0);
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_done",  32'(bus.done),  32'd0);
    check("abort_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b0;
    model_rdata = 16'h0000;
    @(negedge clk);
    skip = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    start(1'b1, 4'h7, 16'h2468, 1'b0, 1'b1);
    wait_done(300);

    // req held high: two back-to-back writes
    repeat (2) @(negedge clk);
    start(1'b1, 4'h1, 16'h1111, 1'b1, 1'b1);
    expect_frame(1'b1, 4'h2, 16'h2222);
    bus.addr = 4'h2; bus.wdata = 16'h2222;
    @(negedge clk);
    b2b = 1'b1;
    wait_done(300);
    @(negedge clk);
    bus.req = 1'b0;
    wait_done(300);
    b2b = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_frames_left", 32'(exp_frame.size()), 32'd0);

    // CLK_DIV=2, GAP_CYCLES=1 read with MISO held high
    bus2.wr = 1'b0; bus2.addr = 4'h2; bus2.req = 1'b1;
    @(negedge clk);
    bus2.req = 1'b0;
    check("d2_ssel", 32'(ssel2), 32'd0);
    for (int k = 1; k <= 200 && dr == 0; k++) begin
      if (sclk2 === 1'b1 && p2 === 1'b0) begin
        if (r1 == 0) r1 = k;
        else if (r2 == 0) r2 = k;
        f2 = {f2[30:0], mosi2};
      end
      p2 = sclk2;
      if (bus2.done === 1'b1) dr = k;
      else @(negedge clk);
    end
    check("d2_first_rise", 32'(r1), 32'd3);
    check("d2_period", 32'(r2 - r1), 32'd4);
    check("d2_done_cycle", 32'(dr), 32'd132);
    check("d2_rdata", 32'(bus2.rdata), 32'hFFFF);
    check("d2_frame", f2, 32'h0002_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master sequencer that drives the team's 32-bit register-access frame to an SPI slave with a 16 x 16 register file. It converts a single-cycle request on a local parallel interface into one complete frame: SSEL assertion, 32 SCLK periods, SSEL release and inter-frame gap. For reads it captures the 16-bit read data from MISO. It sits on the FPGA fabric side and is the only agent that initiates slave register reads and writes.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal values are 2 to 255.
- GAP_CYCLES, 4: minimum number of clk cycles that SSEL stays high between frames; legal values are 1 to 255.

- clk  in  1  system clock; all logic is on posedge clk.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; captured with req.
- addr  in  4  register address; captured with req.
- wdata  in  16  write data; captured with req.
- busy  out  1  high from the cycle after acceptance until the done cycle.
- done  out  1  one-cycle completion pulse.
- rdata  out  16  read result; valid from the done cycle; holds until the next read completes.
- sclk  out  1  SPI clock; idles low.
- ssel  out  1  slave select, active low; idles high.
- mosi  out  1  serial data to the slave, MSB first.
- miso  in  1  serial data from the slave.

## Operation
- Frame is 32 bits, MSB first:
  - command word {wr, 11'b0, addr}
  - followed by a 16-bit data word: wdata for a write, don't-care zeros for a read.
- States:
  - IDLE -> SHIFT on req while in IDLE. Captures wr, addr and wdata into a 32-bit shift register.
  - SHIFT: 32 bit periods. Each period is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - HOLD: SCLK low for CLK_DIV cycles, then -> GAP.
  - GAP: SSEL high for GAP_CYCLES cycles, then -> IDLE with done pulsed.
- mosi changes only at the start of a low phase. The slave samples it on the rising edge.
- Read data: for bits 16..31, miso is sampled in the last clk cycle of each high phase and shifted into a 16-bit capture register.
  - rdata is loaded from the capture register in the done cycle, only for reads.
  - Writes leave rdata unchanged.
- req while busy is ignored; it is not queued.
- req held continuously starts back-to-back frames. A new acceptance is possible in the done cycle.
- Reset values:
  - outputs: busy=0, done=0, rdata=0, sclk=0, ssel=1, mosi=0
  - state: IDLE, with all counters cleared
- rst mid-frame aborts at the next edge with the values above and no done pulse. The slave observes SSEL rising.

## Timing
- Cycle 0 is the acceptance edge (req=1 in IDLE).
- busy=1, ssel=0 and mosi=bit31 hold from cycle 1.
- Rising edge of bit k (k = 0..31, counted from the MSB) occurs at cycle 1 + CLK_DIV*(2k+1).
- ssel is low for cycles 1 .. 65*CLK_DIV, i.e. 64*CLK_DIV for SHIFT plus CLK_DIV for HOLD.
- ssel rises at cycle 65*CLK_DIV+1.
- done=1 and busy=0 occur at cycle 65*CLK_DIV + GAP_CYCLES + 1. This is 265 with the defaults.
- The SSEL-high gap between back-to-back frames is exactly GAP_CYCLES+1 cycles.
- sclk, ssel and mosi are registered outputs with no combinational path from inputs.
- Counters:
  - half-period counter is 8 bits and wraps to 0 at CLK_DIV-1
  - bit counter is 6 bits, 0..32
  - gap counter is 8 bits

## Structure
- Shared package spi_pkg:
  - FRAME_BITS=32, DATA_W=16, ADDR_W=4, CMD_WR_BIT=15
  - state enum IDLE/SHIFT/HOLD/GAP
  - command-word build function
- One sub-module, spi_sclk_gen. It is a half-period counter that outputs the sclk level plus one-cycle rise_stb and fall_stb strobes. It is enabled in SHIFT and held in reset otherwise.

## Test plan
- Write, addr=3, wdata=16'hA5C3, defaults:
  - the bench samples mosi on 32 sclk rises and reads 32'h8003A5C3
  - ssel is low for exactly 260 cycles
  - done pulses at cycle 265 and rdata stays 0.
- Read, addr=9, with a miso model driving 16'h1234 on data bits:
  - mosi command is 16'h0009
  - rdata=16'h1234 in the done cycle and holds after.
- req pulsed at cycles 10 and 100 during a frame: both are ignored, exactly one done occurs, and the frame content is unchanged.
- rst asserted at cycle 50 of a frame:
  - next edge gives ssel=1, sclk=0, mosi=0, busy=0, with no done
  - a new req at cycle 55 produces a complete, correct frame.
- req held high with two different writes:
  - second ssel fall occurs in cycle done+1
  - SSEL-high gap is 5 cycles
  - second frame content is correct.
- CLK_DIV=2, GAP_CYCLES=1, read of 16'hFFFF:
  - sclk period is 4 cycles
  - done at cycle 132
  - rdata=16'hFFFF.
